flash_wave_loader: RTL and testbench
====================================

Name: flash_wave_loader

Overview:
- Sequencer that copies a waveform table from serial flash into the on-chip wave RAM after power-up or on a reload command.
- Sits directly upstream of flash_ctrl: issues byte reads (rd/raddr), consumes the returned bytes (rdata/rdv), packs them MSB-first into samples, and writes the samples to the wave RAM write port.
- One transfer per start pulse; reports busy, done and a sticky timeout error.

Parameters:
- FADDR_NBIT, 24, flash byte address width (matches flash_ctrl raddr).
- FDATA_NBIT, 8, flash data width per read.
- SAMPLE_NBIT, 16, wave sample width; must be an integer multiple of FDATA_NBIT.
- WADDR_NBIT, 10, wave RAM address width.
- TIMEOUT, 4096, mclk cycles allowed per byte read before error.
- TO_NBIT, 13, timeout counter width (≥ clog2(TIMEOUT+1)).

Ports:
- mclk, input, 1, main clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle load request; sampled only in IDLE.
- base_addr, input, FADDR_NBIT, first flash byte address; latched on accepted start.
- nsamp, input, WADDR_NBIT+1, number of samples to load; latched on accepted start.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse at the end of a transfer.
- err, output, 1, sticky timeout flag; cleared by rst or by an accepted start.
- flash_rd, output, 1, one-cycle read request to flash_ctrl.
- flash_raddr, output, FADDR_NBIT, read byte address; held stable from flash_rd until the byte returns.
- flash_rstatus, input, 1, flash_ctrl idle indication.
- flash_rdata, input, FDATA_NBIT, returned byte.
- flash_rdv, input, 1, flash_ctrl data valid (level); its rising edge marks a new byte.
- wr_en, output, 1, wave RAM write strobe, one cycle per sample.
- wr_addr, output, WADDR_NBIT, sample index, starting at 0.
- wr_data, output, SAMPLE_NBIT, packed sample.

Behaviour:
- Reset: state IDLE. busy, done, err, flash_rd, wr_en = 0. flash_raddr, wr_addr, wr_data, byte counter, sample counter and timeout counter = 0. rdv_d = 0.
- rdv_d registers flash_rdv every cycle. A byte event is flash_rdv & ~rdv_d; it is acted on only in WAIT.
- States:
  - IDLE:
    - On start: latch base_addr and nsamp, clear err, and clear sample/byte counters.
    - If nsamp == 0: go DONE directly (no flash access, no write).
    - Otherwise: busy = 1, go REQ.
    - start while busy is ignored.
  - REQ: wait for flash_rstatus = 1. Then assert flash_rd for exactly one cycle with the current flash_raddr, clear the timeout counter, and go WAIT. This guarantees any in-flight flash read, including one left over from before a reset, finishes first.
  - WAIT:
    - The timeout counter increments each cycle.
    - On a byte event: shift the byte into the sample assembly register (first byte lands in the MSBs) and increment flash_raddr (wraps modulo 2^FADDR_NBIT).
      - If the sample is now complete (SAMPLE_NBIT/FDATA_NBIT bytes): go WRITE.
      - Otherwise: go REQ.
    - If the counter reaches TIMEOUT-1 with no byte event: set err and go DONE. The partial sample is discarded.
  - WRITE: wr_en = 1 for one cycle with wr_data = assembled sample and wr_addr = sample count. Then increment the sample count (wr_addr wraps modulo 2^WADDR_NBIT).
    - If the incremented count equals nsamp: go DONE.
    - Otherwise: go REQ.
  - DONE: done = 1 for one cycle, busy = 0, then IDLE.
- Latency per byte = flash_ctrl transaction time + 2 mclk (REQ issue and edge detect). One extra cycle per sample for WRITE.
- Rising-edge detection is mandatory because flash_rdv stays high between reads.
- rst mid-transfer: abort immediately to the reset state. No done pulse. Already-written RAM contents are left as is.

Test Plan:
- Flash model holds bytes 0x12,0x34,0xAB,0xCD at 0x000100. With base_addr=0x000100, nsamp=2, start pulse: flash_rd issued 4 times with raddr 0x100..0x103; wr_en at wr_addr 0 with wr_data 0x1234, then wr_addr 1 with 0xABCD; one done pulse; err = 0.
- nsamp=0 with start: done pulses within 2 cycles of start; no flash_rd, no wr_en; busy never asserted for more than 1 cycle.
- Model never raises rdv, TIMEOUT=64: err = 1 after 64 WAIT cycles, done pulses, no wr_en; a following start clears err.
- Hold flash_rdv high before start (stale level): first byte is captured only after rdv drops and rises again; data stays correct.
- Pulse start 3 times while busy: only one transfer occurs and exactly nsamp writes are made.
- Assert rst after the 3rd byte of a 4-sample load: all outputs go to 0 the next cycle with no done pulse. A new start with base 0xFFFFFE, nsamp=2: flash_raddr wraps to 0x000000 and 0x000001 for bytes 3 and 4.

Source files
------------

// File: rtl/flash_wave_loader.sv
// Copies a waveform table from serial flash (via flash_ctrl) into the wave RAM,
// packing FDATA_NBIT bytes MSB-first into SAMPLE_NBIT samples.
module flash_wave_loader #(
    parameter int FADDR_NBIT  = 24,
    parameter int FDATA_NBIT  = 8,
    parameter int SAMPLE_NBIT = 16,
    parameter int WADDR_NBIT  = 10,
    parameter int TIMEOUT     = 4096,
    parameter int TO_NBIT     = 13
) (
    input  logic                   mclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FADDR_NBIT-1:0]  base_addr,
    input  logic [WADDR_NBIT:0]    nsamp,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   flash_rd,
    output logic [FADDR_NBIT-1:0]  flash_raddr,
    input  logic                   flash_rstatus,
    input  logic [FDATA_NBIT-1:0]  flash_rdata,
    input  logic                   flash_rdv,
    output logic                   wr_en,
    output logic [WADDR_NBIT-1:0]  wr_addr,
    output logic [SAMPLE_NBIT-1:0] wr_data,
    output logic [2:0]             dbg_state
);

    localparam int BPS     = SAMPLE_NBIT / FDATA_NBIT;
    localparam int BC_NBIT = (BPS > 1) ? $clog2(BPS) : 1;
    localparam logic [BC_NBIT-1:0] BC_LAST = BC_NBIT'(BPS - 1);
    localparam logic [TO_NBIT-1:0] TO_LAST = TO_NBIT'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   rd_q, rd_d;
    logic                   rdv_q;
    logic [FADDR_NBIT-1:0]  raddr_q, raddr_d;
    logic [WADDR_NBIT:0]    nsamp_q, nsamp_d;
    logic [WADDR_NBIT:0]    samp_cnt_q, samp_cnt_d;
    logic [BC_NBIT-1:0]     byte_cnt_q, byte_cnt_d;
    logic [TO_NBIT-1:0]     to_cnt_q, to_cnt_d;
    logic [SAMPLE_NBIT-1:0] asm_q, asm_d;
    logic [SAMPLE_NBIT+FDATA_NBIT-1:0] asm_shift;
    logic                   byte_evt;

    // flash_rdv is a level that stays high between reads, so only its rising
    // edge marks a fresh byte; flash_rd is issued only when flash_rstatus is high.
    assign byte_evt  = flash_rdv & ~rdv_q;
    assign asm_shift = {asm_q, flash_rdata};

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        err_d      = err_q;
        rd_d       = 1'b0;
        raddr_d    = raddr_q;
        nsamp_d    = nsamp_q;
        samp_cnt_d = samp_cnt_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        asm_d      = asm_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    raddr_d    = base_addr;
                    nsamp_d    = nsamp;
                    err_d      = 1'b0;
                    samp_cnt_d = '0;
                    byte_cnt_d = '0;
                    if (nsamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flash_rstatus) begin
                    rd_d     = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (byte_evt) begin
                    asm_d   = asm_shift[SAMPLE_NBIT-1:0];
                    raddr_d = raddr_q + 1'b1;
                    if (byte_cnt_q == BC_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = S_REQ;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                samp_cnt_d = samp_cnt_q + 1'b1;
                if (samp_cnt_d == nsamp_q) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            rdv_q      <= 1'b0;
            raddr_q    <= '0;
            nsamp_q    <= '0;
            samp_cnt_q <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            rdv_q      <= flash_rdv;
            raddr_q    <= raddr_d;
            nsamp_q    <= nsamp_d;
            samp_cnt_q <= samp_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            asm_q      <= asm_d;
        end
    end

    assign busy        = busy_q;
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign flash_rd    = rd_q;
    assign flash_raddr = raddr_q;
    assign wr_en       = (state_q == S_WRITE);
    assign wr_addr     = samp_cnt_q[WADDR_NBIT-1:0];
    assign wr_data     = asm_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_flash_wave_loader.sv
// Directed bench for flash_wave_loader with a behavioural flash_ctrl model.
module tb_flash_wave_loader;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [10:0] nsamp = '0;
    logic        busy, done, err, flash_rd, wr_en;
    logic [23:0] flash_raddr;
    logic        flash_rstatus;
    logic [7:0]  flash_rdata;
    logic        flash_rdv;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  dbg_state;

    flash_wave_loader #(
        .FADDR_NBIT(24), .FDATA_NBIT(8), .SAMPLE_NBIT(16), .WADDR_NBIT(10),
        .TIMEOUT(64), .TO_NBIT(7)
    ) dut (
        .mclk(mclk), .rst(rst), .start(start), .base_addr(base_addr), .nsamp(nsamp),
        .busy(busy), .done(done), .err(err), .flash_rd(flash_rd), .flash_raddr(flash_raddr),
        .flash_rstatus(flash_rstatus), .flash_rdata(flash_rdata), .flash_rdv(flash_rdv),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 mclk = ~mclk;
    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int start_cyc = 0;
    logic dead = 1'b0;

    // observation queues and counters, written only by the monitor
    logic [23:0] rd_q[$];
    logic [25:0] wr_q[$];
    int done_cnt = 0, busy_cnt = 0, done_cyc = 0, rd_cyc = 0;
    logic [25:0] exp_q[$];
    logic [23:0] exp_rd[$];

    always @(negedge mclk) begin
        if (flash_rd) begin
            rd_q.push_back(flash_raddr);
            rd_cyc = cyc;
        end
        if (wr_en) wr_q.push_back({wr_addr, wr_data});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: fbyte = 8'h12;
            24'h000101: fbyte = 8'h34;
            24'h000102: fbyte = 8'hAB;
            24'h000103: fbyte = 8'hCD;
            default:    fbyte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // flash_ctrl model: rdv falls two cycles after a request, byte arrives three later
    initial begin
        logic [23:0] a;
        flash_rdv = 1'b0;
        flash_rstatus = 1'b1;
        flash_rdata = 8'h00;
        forever begin
            @(posedge mclk);
            #1;
            if (flash_rd) begin
                a = flash_raddr;
                if (!dead) flash_rstatus = 1'b0;
                repeat (2) @(posedge mclk);
                #1 flash_rdv = 1'b0;
                if (!dead) begin
                    repeat (3) @(posedge mclk);
                    #1;
                    flash_rdata = fbyte(a);
                    flash_rdv = 1'b1;
                    flash_rstatus = 1'b1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [23:0] b, input logic [10:0] n);
        @(posedge mclk);
        #1;
        base_addr = b;
        nsamp = n;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge mclk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int max_cyc);
        int n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            @(posedge mclk);
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        repeat (2) @(posedge mclk);
    endtask

    task automatic check_writes(input string tag, input int w0);
        check_eq({tag, "_wr_count"}, 32'(wr_q.size() - w0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (w0 + i < wr_q.size()) check_eq({tag, "_wr"}, 32'(wr_q[w0+i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic check_reads(input string tag, input int r0);
        check_eq({tag, "_rd_count"}, 32'(rd_q.size() - r0), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size(); i++)
            if (r0 + i < rd_q.size()) check_eq({tag, "_raddr"}, 32'(rd_q[r0+i]), 32'(exp_rd[i]));
        exp_rd.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_rd"}, 32'(flash_rd), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_eq({tag, "_raddr"}, 32'(flash_raddr), 32'd0);
        check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_eq({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int r0, w0, d0, b0, n;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check_idle_outputs("reset");
        @(posedge mclk);
        #1 rst = 1'b0;

        // basic two-sample load
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        exp_rd = '{24'h100, 24'h101, 24'h102, 24'h103};
        exp_q = '{{10'd0, 16'h1234}, {10'd1, 16'hABCD}};
        pulse_start(24'h000100, 11'd2);
        wait_done("basic", d0, 300);
        check_reads("basic", r0);
        check_writes("basic", w0);
        check_eq("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("basic_err", 32'(err), 32'd0);

        // zero-sample request
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt; b0 = busy_cnt;
        pulse_start(24'h000100, 11'd0);
        wait_done("zero", d0, 10);
        check_eq("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        check_eq("zero_rd", 32'(rd_q.size() - r0), 32'd0);
        check_eq("zero_wr", 32'(wr_q.size() - w0), 32'd0);
        check_eq("zero_busy_le1", 32'(busy_cnt - b0 <= 1), 32'd1);

        // timeout: flash never returns a byte
        dead = 1'b1;
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        pulse_start(24'h000100, 11'd1);
        wait_done("tmo", d0, 300);
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_wait_cycles", 32'(done_cyc - rd_cyc), 32'd64);
        check_eq("tmo_rd", 32'(rd_q.size() - r0), 32'd1);
        check_eq("tmo_wr", 32'(wr_q.size() - w0), 32'd0);
        dead = 1'b0;
        w0 = wr_q.size(); d0 = done_cnt;
        exp_q = '{{10'd0, 16'h1234}};
        pulse_start(24'h000100, 11'd1);
        check_eq("tmo_err_cleared", 32'(err), 32'd0);
        wait_done("tmo2", d0, 300);
        check_writes("tmo2", w0);

        // rdv still high from the previous read when this load starts
        check_eq("stale_rdv_high", 32'(flash_rdv), 32'd1);
        w0 = wr_q.size(); d0 = done_cnt;
        exp_q = '{{10'd0, 16'hABCD}};
        pulse_start(24'h000102, 11'd1);
        wait_done("stale", d0, 300);
        check_writes("stale", w0);

        // extra start pulses while busy are ignored
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        exp_rd = '{24'h100, 24'h101, 24'h102, 24'h103};
        exp_q = '{{10'd0, 16'h1234}, {10'd1, 16'hABCD}};
        pulse_start(24'h000100, 11'd2);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(posedge mclk);
            pulse_start(24'h000200, 11'd5);
        end
        wait_done("multi", d0, 300);
        repeat (30) @(posedge mclk);
        check_reads("multi", r0);
        check_writes("multi", w0);
        check_eq("multi_done_cnt", 32'(done_cnt - d0), 32'd1);

        // reset in the middle of a four-sample load
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        pulse_start(24'h000200, 11'd4);
        n = 0;
        while (rd_q.size() - r0 < 4 && n < 300) begin
            @(posedge mclk);
            n++;
        end
        check_eq("rst_reached_byte3", 32'(rd_q.size() - r0 >= 4), 32'd1);
        @(posedge mclk);
        #1 rst = 1'b1;
        @(posedge mclk);
        #1 rst = 1'b0;
        @(negedge mclk);
        check_idle_outputs("midrst");
        repeat (10) @(posedge mclk);
        check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q = '{{10'd0, 16'hA5A4}};
        check_writes("midrst", w0);

        // address wrap across the top of flash
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        exp_rd = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        exp_q = '{{10'd0, 16'h5B5A}, {10'd1, 16'hA5A4}};
        pulse_start(24'hFFFFFE, 11'd2);
        wait_done("wrap", d0, 300);
        check_reads("wrap", r0);
        check_writes("wrap", w0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
